// File: rtl/ldpc_pkg.sv
// ldpc_pkg: definitions shared by the LDPC core and the syndrome checker:
// null-shift test, status encodings and the checker state enum.
package ldpc_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } ldpc_state_e;

  // A shift entry with its sign bit set marks an all-zero (null) block.
  function automatic logic null_shift(input logic [31:0] entry, input logic [4:0] msb);
    return entry[msb];
  endfunction

endpackage

// File: rtl/ldpc_circ_xor.sv
// ldpc_circ_xor: combinational syndrome of one base-matrix block row.
// Each non-null entry k rotates its D-bit block of s so that output bit i
// picks s[r*D + (i+k)%D]; the rotated blocks are XORed together.
// Entries >= D are treated as null and flagged on o_bad.
module ldpc_circ_xor
  import ldpc_pkg::*;
#(
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int data_w = 8
) (
  input  logic [R*data_w-1:0] i_row,
  input  logic [R*D-1:0]      i_s,
  output logic [D-1:0]        o_syn,
  output logic                o_bad
);

  localparam logic [data_w:0] D_LIM = (data_w + 1)'(D);

  // XOR the circularly shifted blocks of the row; collect out-of-range shifts.
  always_comb begin
    logic [data_w-1:0] w_k;
    logic [D-1:0]      w_rot;
    logic              w_null;
    logic              w_over;
    o_syn  = {D{1'b0}};
    o_bad  = 1'b0;
    w_k    = {data_w{1'b0}};
    w_rot  = {D{1'b0}};
    w_null = 1'b0;
    w_over = 1'b0;
    for (int r = 0; r < R; r++) begin
      w_k    = i_row[r*data_w +: data_w];
      w_rot  = D'({i_s[r*D +: D], i_s[r*D +: D]} >> w_k);
      w_null = null_shift(32'(w_k), 5'(data_w - 1));
      w_over = !w_null && ({1'b0, w_k} >= D_LIM);
      o_bad  = o_bad | w_over;
      o_syn  = o_syn ^ ((w_null || w_over) ? {D{1'b0}} : w_rot);
    end
  end

endmodule

// File: rtl/ldpc_syndrome_chk.sv
// ldpc_syndrome_chk: QC-LDPC syndrome checker. Snapshots the shift table and
// hard decisions, evaluates P block rows per enabled cycle and reports
// pass/fail on a one-cycle done pulse.
// Optional feature macro LDPC_SYND_CNT_EN: adds the unsat_cnt port (total
// unsatisfied check bits) and disables early exit.
module ldpc_syndrome_chk
  import ldpc_pkg::*;
#(
  parameter int C      = 12,
  parameter int R      = 24,
  parameter int D      = 96,
  parameter int data_w = 8,
  parameter int P      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic [C*R*data_w-1:0]  m,
  input  logic [R*D-1:0]         s,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic                   bad_shift
`ifdef LDPC_SYND_CNT_EN
  ,
  output logic [$clog2(C*D+1)-1:0] unsat_cnt
`endif
);

  localparam int G  = (C + P - 1) / P;
  localparam int GW = $clog2(G + 1);
  localparam int CW = $clog2(C*D + 1);

  ldpc_state_e              r_state;
  ldpc_state_e              w_nxt;
  logic [C*R*data_w-1:0]    r_m;
  logic [R*D-1:0]           r_s;
  logic [GW-1:0]            r_grp;
  logic                     r_nz;
  logic                     r_fin;
  logic                     r_bad;
  logic                     r_busy;
  logic                     r_done;
  logic [1:0]               r_status;

  logic [P-1:0][R*data_w-1:0] w_row;
  logic [P-1:0][D-1:0]        w_syn;
  logic [P-1:0]               w_bad;
  logic [P-1:0]               w_vld;
  logic                       w_grp_nz;
  logic                       w_grp_bad;
  logic                       w_early;
  logic                       w_last;

  // Pick the table rows of the current group; rows past C are masked.
  always_comb begin
    w_row = '0;
    w_vld = '0;
    for (int p = 0; p < P; p++) begin
      for (int cc = 0; cc < C; cc++) begin
        w_row[p] = (int'(r_grp) * P + p == cc) ? r_m[cc*R*data_w +: R*data_w] : w_row[p];
        w_vld[p] = (int'(r_grp) * P + p == cc) ? 1'b1 : w_vld[p];
      end
    end
  end

  for (genvar gp = 0; gp < P; gp++) begin : g_row
    ldpc_circ_xor #(
      .R      (R),
      .D      (D),
      .data_w (data_w)
    ) u_xor (
      .i_row (w_row[gp]),
      .i_s   (r_s),
      .o_syn (w_syn[gp]),
      .o_bad (w_bad[gp])
    );
  end

  // Reduce the per-row results of this group to nonzero / bad-shift flags.
  always_comb begin
    w_grp_nz  = 1'b0;
    w_grp_bad = 1'b0;
    for (int p = 0; p < P; p++) begin
      w_grp_nz  = w_grp_nz  | (w_vld[p] & (|w_syn[p]));
      w_grp_bad = w_grp_bad | (w_vld[p] & w_bad[p]);
    end
  end

  assign w_last = (r_grp == GW'(G - 1));

`ifdef LDPC_SYND_CNT_EN
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_grp_pop;

  assign w_early = 1'b0;

  // Popcount of all unsatisfied check bits in the current group.
  always_comb begin
    w_grp_pop = {CW{1'b0}};
    for (int p = 0; p < P; p++) begin
      for (int i = 0; i < D; i++) begin
        w_grp_pop = w_grp_pop + CW'(w_vld[p] & w_syn[p][i]);
      end
    end
  end

  // Accumulate the unsatisfied count across groups of one check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (en) begin
      if (r_state == S_IDLE && start) begin
        r_cnt <= {CW{1'b0}};
      end else if (r_state == S_RUN && !r_fin) begin
        r_cnt <= r_cnt + w_grp_pop;
      end
    end
  end

  assign unsat_cnt = r_cnt;
`else
  assign w_early = w_grp_nz;
`endif

  // Next-state logic: RUN lasts until the finish flag has been registered.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   w_nxt = r_fin ? S_DONE : S_RUN;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register; en low freezes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_nxt;
    end
  end

  // Snapshot, group walk, sticky flags and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m      <= '0;
      r_s      <= '0;
      r_grp    <= {GW{1'b0}};
      r_nz     <= 1'b0;
      r_fin    <= 1'b0;
      r_bad    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_status <= ST_NONE;
    end else if (en) begin
      r_busy <= (w_nxt == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m      <= m;
            r_s      <= s;
            r_grp    <= {GW{1'b0}};
            r_nz     <= 1'b0;
            r_fin    <= 1'b0;
            r_bad    <= 1'b0;
            r_status <= ST_NONE;
          end
        end
        S_RUN: begin
          if (!r_fin) begin
            r_nz  <= r_nz | w_grp_nz;
            r_bad <= r_bad | w_grp_bad;
            r_grp <= r_grp + GW'(1);
            r_fin <= w_last | w_early;
          end else begin
            r_done   <= 1'b1;
            r_status <= r_nz ? ST_FAIL : ST_PASS;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign status    = r_status;
  assign bad_shift = r_bad;

endmodule

// File: tb/tb_ldpc_syndrome_chk.sv
// tb_ldpc_syndrome_chk: directed checks of ldpc_syndrome_chk with
// C=2,R=4,D=8,P=1 (dut1) and C=3,R=4,D=8,P=2 (dut2).
// Builds with or without LDPC_SYND_CNT_EN.
module tb_ldpc_syndrome_chk;

`ifdef LDPC_SYND_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        start1;
  logic        start2;
  logic [63:0] m1;
  logic [95:0] m2;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        busy1, done1, bad1;
  logic        busy2, done2, bad2;
  logic [1:0]  status1, status2;
`ifdef LDPC_SYND_CNT_EN
  logic [4:0]  cnt1, cnt2;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 0;

  ldpc_syndrome_chk #(.C(2), .R(4), .D(8), .data_w(8), .P(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start1),
    .m         (m1),
    .s         (s1),
    .busy      (busy1),
    .done      (done1),
    .status    (status1),
    .bad_shift (bad1)
`ifdef LDPC_SYND_CNT_EN
    ,
    .unsat_cnt (cnt1)
`endif
  );

  ldpc_syndrome_chk #(.C(3), .R(4), .D(8), .data_w(8), .P(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start2),
    .m         (m2),
    .s         (s2),
    .busy      (busy2),
    .done      (done2),
    .status    (status2),
    .bad_shift (bad2)
`ifdef LDPC_SYND_CNT_EN
    ,
    .unsat_cnt (cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after the accepting edge.
  task automatic kick(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b1;
    else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(input int which, input int lat0, output int l);
    l = lat0;
    while (((which == 1) ? done1 : done2) !== 1'b1 && l < 40) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    en = 1'b1; start1 = 1'b0; start2 = 1'b0;
    m1 = {8{8'hFF}}; s1 = 32'd0;
    m2 = {12{8'hFF}}; s2 = 32'd0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",   32'(busy1),   32'd0);
    chk("rst_done",   32'(done1),   32'd0);
    chk("rst_status", 32'(status1), 32'd0);
    chk("rst_bad",    32'(bad1),    32'd0);
`ifdef LDPC_SYND_CNT_EN
    chk("rst_cnt",    32'(cnt1),    32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // All-zero s: full run, pass
    kick(1);
    chk("zero_busy", 32'(busy1), 32'd1);
    wait_done(1, 0, lat);
    chk("zero_lat",    32'(lat),     32'd3);
    chk("zero_status", 32'(status1), 32'd1);
    chk("zero_bad",    32'(bad1),    32'd0);
`ifdef LDPC_SYND_CNT_EN
    chk("zero_cnt",    32'(cnt1),    32'd0);
`endif
    // done held while stalled in DONE
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_done_hold", 32'(done1), 32'd1);
    en = 1'b1;
    @(negedge clk);
    chk("done_pulse_end", 32'(done1),   32'd0);
    chk("idle_busy",      32'(busy1),   32'd0);
    chk("status_hold",    32'(status1), 32'd1);

    // (0,0)=3, (1,0)=0, s[0]=1: row0 bit5 and row1 bit0 unsatisfied
    m1 = {8{8'hFF}};
    m1[(0*4+0)*8 +: 8] = 8'd3;
    m1[(1*4+0)*8 +: 8] = 8'd0;
    s1 = 32'h0000_0001;
    kick(1);
    wait_done(1, 0, lat);
    chk("fail_lat",    32'(lat),     CNT ? 32'd3 : 32'd2);
    chk("fail_status", 32'(status1), 32'd2);
`ifdef LDPC_SYND_CNT_EN
    chk("fail_cnt",    32'(cnt1),    32'd2);
`endif
    repeat (3) @(negedge clk);
    chk("fail_status_hold", 32'(status1), 32'd2);

    // (0,0)=(0,1)=2, s[0]=s[8]=1: contributions cancel
    m1 = {8{8'hFF}};
    m1[(0*4+0)*8 +: 8] = 8'd2;
    m1[(0*4+1)*8 +: 8] = 8'd2;
    s1 = 32'h0000_0101;
    kick(1);
    chk("accept_clears_status", 32'(status1), 32'd0);
    wait_done(1, 0, lat);
    chk("cancel_lat",    32'(lat),     32'd3);
    chk("cancel_status", 32'(status1), 32'd1);

    // (1,3)=8 is out of range: null block, bad_shift set, s[24] ignored
    m1 = {8{8'hFF}};
    m1[(1*4+3)*8 +: 8] = 8'd8;
    s1 = 32'h0100_0000;
    kick(1);
    wait_done(1, 0, lat);
    chk("bad_lat",    32'(lat),     32'd3);
    chk("bad_status", 32'(status1), 32'd1);
    chk("bad_flag",   32'(bad1),    32'd1);

    // (1,2)=5, s[16]=1: only row1 bit3 unsatisfied
    m1 = {8{8'hFF}};
    m1[(1*4+2)*8 +: 8] = 8'd5;
    s1 = 32'h0001_0000;
    kick(1);
    chk("accept_clears_bad", 32'(bad1), 32'd0);
    wait_done(1, 0, lat);
    chk("row1_lat",    32'(lat),     32'd3);
    chk("row1_status", 32'(status1), 32'd2);
`ifdef LDPC_SYND_CNT_EN
    chk("row1_cnt",    32'(cnt1),    32'd1);
`endif

    // en low for 4 cycles in RUN adds 4 to latency
    m1 = {8{8'hFF}};
    s1 = 32'd0;
    kick(1);
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_done(1, 5, lat);
    chk("stall_lat",    32'(lat),     32'd7);
    chk("stall_status", 32'(status1), 32'd1);

    // start during RUN ignored; inputs changing after acceptance ignored
    m1 = {8{8'hFF}};
    s1 = 32'd0;
    kick(1);
    start1 = 1'b1;
    m1 = {8{8'h00}};
    s1 = 32'hFFFF_FFFE;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1, 1, lat);
    chk("snap_lat",    32'(lat),     32'd3);
    chk("snap_status", 32'(status1), 32'd1);
    @(negedge clk);
    chk("no_restart_busy", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    chk("no_restart_done", 32'(done1), 32'd0);
    chk("no_restart_busy2", 32'(busy1), 32'd0);

    // Reset mid-RUN after bad_shift has been raised
    m1 = {8{8'hFF}};
    m1[(1*4+3)*8 +: 8] = 8'd8;
    s1 = 32'd0;
    kick(1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_bad", 32'(bad1), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(busy1),   32'd0);
    chk("mid_rst_done",   32'(done1),   32'd0);
    chk("mid_rst_status", 32'(status1), 32'd0);
    chk("mid_rst_bad",    32'(bad1),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy1), 32'd0);
    m1 = {8{8'hFF}};
    m1[(0*4+0)*8 +: 8] = 8'd3;
    m1[(1*4+0)*8 +: 8] = 8'd0;
    s1 = 32'h0000_0001;
    kick(1);
    wait_done(1, 0, lat);
    chk("post_rst_lat",    32'(lat),     CNT ? 32'd3 : 32'd2);
    chk("post_rst_status", 32'(status1), 32'd2);

    // P=2, C=3: G=2
    kick(2);
    chk("p2_busy", 32'(busy2), 32'd1);
    wait_done(2, 0, lat);
    chk("p2_lat",    32'(lat),     32'd3);
    chk("p2_status", 32'(status2), 32'd1);
    chk("p2_bad",    32'(bad2),    32'd0);
    // row 2 (second group) fails on bit 0
    m2 = {12{8'hFF}};
    m2[(2*4+0)*8 +: 8] = 8'd0;
    s2 = 32'h0000_0001;
    kick(2);
    wait_done(2, 0, lat);
    chk("p2_row2_lat",    32'(lat),     32'd3);
    chk("p2_row2_status", 32'(status2), 32'd2);
`ifdef LDPC_SYND_CNT_EN
    chk("p2_row2_cnt",    32'(cnt2),    32'd1);
`endif
    // row 1 (first group, second lane) fails on bit 0
    m2 = {12{8'hFF}};
    m2[(1*4+0)*8 +: 8] = 8'd0;
    kick(2);
    wait_done(2, 0, lat);
    chk("p2_row1_lat",    32'(lat),     CNT ? 32'd3 : 32'd2);
    chk("p2_row1_status", 32'(status2), 32'd2);
`ifdef LDPC_SYND_CNT_EN
    chk("p2_row1_cnt",    32'(cnt2),    32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
